// File: rtl/keccak_chi_iter.sv
// keccak_chi_iter: handshaked in-place Keccak chi, ROWS_PER_CYCLE rows per clock.
// Define KECCAK_CHI_IOTA_EN to add the rc_in port and fuse iota into row 0.
module keccak_chi_iter #(
    parameter int LANE_W = 64,
    parameter int ROWS_PER_CYCLE = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [4:0][4:0][LANE_W-1:0]   state_in,
`ifdef KECCAK_CHI_IOTA_EN
    input  logic [LANE_W-1:0]             rc_in,
`endif
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [4:0][4:0][LANE_W-1:0]   state_out,
    output logic                          busy
);
    if ((ROWS_PER_CYCLE != 1 && ROWS_PER_CYCLE != 5) ||
        (LANE_W != 8 && LANE_W != 16 && LANE_W != 32 && LANE_W != 64)) begin : g_bad_param
        $error("keccak_chi_iter: illegal LANE_W or ROWS_PER_CYCLE");
    end
    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;
    localparam logic [2:0] STEP = 3'(ROWS_PER_CYCLE);
    localparam logic [2:0] LAST = 3'(5 - ROWS_PER_CYCLE);
    fsm_t fsm;
    logic [2:0] row_cnt;
    logic [4:0][4:0][LANE_W-1:0] st, chi;
`ifdef KECCAK_CHI_IOTA_EN
    logic [LANE_W-1:0] rc;
`endif
    assign state_out = st;
    // Rows are independent, so only the selected rows are rewritten in place.
    always_comb begin
        chi = st;
        for (int y = 0; y < 5; y++)
            if (y >= int'(row_cnt) && y < int'(row_cnt) + ROWS_PER_CYCLE)
                for (int x = 0; x < 5; x++)
                    chi[x][y] = st[x][y] ^ (~st[(x+1)%5][y] & st[(x+2)%5][y]);
`ifdef KECCAK_CHI_IOTA_EN
        if (row_cnt == 3'd0) chi[0][0] = chi[0][0] ^ rc;
`endif
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fsm       <= IDLE;
            st        <= '0;
            row_cnt   <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
`ifdef KECCAK_CHI_IOTA_EN
            rc        <= '0;
`endif
        end else begin
            case (fsm)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        st       <= state_in;
`ifdef KECCAK_CHI_IOTA_EN
                        rc       <= rc_in;
`endif
                        row_cnt  <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        fsm      <= RUN;
                    end
                end
                RUN: begin
                    st <= chi;
                    if (row_cnt == LAST) begin
                        row_cnt   <= '0;
                        out_valid <= 1'b1;
                        fsm       <= DONE;
                    end else begin
                        row_cnt <= row_cnt + STEP;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        fsm       <= IDLE;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_keccak_chi_iter.sv
// tb_keccak_chi_iter: directed vectors for chi on a 64-bit/1-row unit and an 8-bit/5-row unit.
module tb_keccak_chi_iter;
    typedef logic [4:0][4:0][63:0] st64_t;
    typedef logic [4:0][4:0][7:0]  st8_t;
    typedef struct {
        string name;
        st64_t a;
        st64_t e;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, in_valid, in_ready, out_valid, out_ready, busy;
    st64_t state_in, state_out;
    logic [63:0] rc_in;
    logic b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
    st8_t b_state_in, b_state_out;
    logic [7:0] b_rc_in;

    int n_cmp = 0;
    int n_bad = 0;

    keccak_chi_iter #(.LANE_W(64), .ROWS_PER_CYCLE(1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .state_in(state_in),
`ifdef KECCAK_CHI_IOTA_EN
        .rc_in(rc_in),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .state_out(state_out), .busy(busy)
    );

    keccak_chi_iter #(.LANE_W(8), .ROWS_PER_CYCLE(5)) dut_b (
        .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .state_in(b_state_in),
`ifdef KECCAK_CHI_IOTA_EN
        .rc_in(b_rc_in),
`endif
        .out_valid(b_out_valid), .out_ready(b_out_ready), .state_out(b_state_out), .busy(b_busy)
    );

    task automatic check(input string name, input logic [1599:0] act, input logic [1599:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Captures a state on the 64-bit unit and waits for out_valid; leaves the result held in DONE.
    task automatic start64(input st64_t a, input logic [63:0] rc, output int lat);
        int c = 0;
        while (!in_ready && c < 20) begin @(negedge clk); c++; end
        if (!in_ready) check("in_ready_timeout", 0, 1);
        state_in = a;
        rc_in    = rc;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        state_in = '0;
        lat = 0;
        while (!out_valid && lat < 20) begin @(negedge clk); lat++; end
    endtask

    task automatic pop64();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    vec_t tv[5];
    st64_t exp_bp, held;
    st8_t  b_a, b_e;
    int lat;
    logic bp_ok;

    initial begin
        tv[0].name = "zero";  tv[0].a = '0; tv[0].e = '0;
        tv[1].name = "ones";  tv[1].a = '1; tv[1].e = '1;
        tv[2].name = "bit00"; tv[2].a = '0; tv[2].a[0][0] = 64'h1;
        tv[2].e = '0; tv[2].e[0][0] = 64'h1; tv[2].e[3][0] = 64'h1;
        tv[3].name = "row1";  tv[3].a = '0;
        tv[3].a[2][1] = 64'hFFFF_FFFF_FFFF_FFFF; tv[3].a[1][1] = 64'h0F0F_0F0F_0F0F_0F0F;
        tv[3].e = '0;
        tv[3].e[0][1] = 64'hF0F0_F0F0_F0F0_F0F0; tv[3].e[1][1] = 64'h0F0F_0F0F_0F0F_0F0F;
        tv[3].e[2][1] = 64'hFFFF_FFFF_FFFF_FFFF; tv[3].e[4][1] = 64'h0F0F_0F0F_0F0F_0F0F;
        tv[4].name = "row4";  tv[4].a = '0;
        tv[4].a[0][4] = 64'hAAAA_AAAA_AAAA_AAAA; tv[4].a[1][4] = 64'hCCCC_CCCC_CCCC_CCCC;
        tv[4].e = '0;
        tv[4].e[0][4] = 64'hAAAA_AAAA_AAAA_AAAA; tv[4].e[1][4] = 64'hCCCC_CCCC_CCCC_CCCC;
        tv[4].e[3][4] = 64'hAAAA_AAAA_AAAA_AAAA; tv[4].e[4][4] = 64'h4444_4444_4444_4444;

        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; state_in = '0; rc_in = '0;
        b_in_valid = 1'b0; b_out_ready = 1'b0; b_state_in = '0; b_rc_in = '0;
        @(negedge clk); @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_state_out", state_out, 0);
        reset = 1'b1;
        @(negedge clk); @(negedge clk);
        check("idle_in_ready", in_ready, 1);

        for (int i = 0; i < 5; i++) begin
            start64(tv[i].a, 64'h0, lat);
            check({tv[i].name, "_lat"}, lat, 5);
            check({tv[i].name, "_busy"}, busy, 1);
            check({tv[i].name, "_out"}, state_out, tv[i].e);
            pop64();
        end

        // Backpressure: result must hold for 10 cycles with out_ready low.
        exp_bp = '0; exp_bp[0][0] = 64'h1; exp_bp[3][0] = 64'h1;
        held = '0; held[0][0] = 64'h1;
        start64(held, 64'h0, lat);
        bp_ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (state_out !== exp_bp || out_valid !== 1'b1 || in_ready !== 1'b0) bp_ok = 1'b0;
            @(negedge clk);
        end
        check("bp_hold", bp_ok, 1);
        check("bp_out", state_out, exp_bp);
        pop64();
        check("bp_out_valid_drop", out_valid, 0);
        check("bp_in_ready_back", in_ready, 1);

        // Reset during the third RUN cycle aborts the operation.
        state_in = '1;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk); @(negedge clk);
        check("abort_busy_pre", busy, 1);
        reset = 1'b0;
        #1;
        check("abort_state_out", state_out, 0);
        check("abort_out_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_in_ready", in_ready, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk); @(negedge clk);
        check("abort_ready_after", in_ready, 1);
        check("abort_no_emit", out_valid, 0);
        start64(tv[4].a, 64'h0, lat);
        check("fresh_lat", lat, 5);
        check("fresh_out", state_out, tv[4].e);
        pop64();

`ifdef KECCAK_CHI_IOTA_EN
        exp_bp = '0; exp_bp[0][0] = 64'h8000_0000_0000_8080;
        start64('0, 64'h8000_0000_0000_8080, lat);
        check("iota_out", state_out, exp_bp);
        pop64();
`endif

        // 8-bit lanes, all five rows in one cycle.
        b_a = '0; b_a[2][1] = 8'hFF; b_a[1][1] = 8'h0F;
        b_e = '0; b_e[0][1] = 8'hF0; b_e[1][1] = 8'h0F; b_e[2][1] = 8'hFF; b_e[4][1] = 8'h0F;
        check("b_in_ready", b_in_ready, 1);
        b_state_in = b_a;
        b_in_valid = 1'b1;
        @(negedge clk);
        b_in_valid = 1'b0;
        lat = 0;
        while (!b_out_valid && lat < 20) begin @(negedge clk); lat++; end
        check("b_lat", lat, 1);
        check("b_out", 1600'(b_state_out), 1600'(b_e));
        b_out_ready = 1'b1;
        @(negedge clk);
        b_out_ready = 1'b0;
        check("b_out_valid_drop", b_out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
